abuf_ctrl: RTL

- Address/sequencing controller for the core activation buffer (dual-port ABUF fed by the CLINK serial-to-parallel path).
- Generates the ABUF write address from the s2p write strobe and tracks occupancy.
- Sequences MAC-side reads: one tile of cfg_len rows, replayed cfg_repeat times for weight reuse, then released.
- Sits between the core's command/config logic and the ABUF/MAC datapath.

---
 rtl/abuf_ctrl_pkg.sv | 17 +
 rtl/abuf_occ_cnt.sv | 56 +++++
 rtl/abuf_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/abuf_ctrl_pkg.sv
// Shared definitions for the activation buffer: default geometry and the
// read-sequencer state encoding, common to core_buf and the MAC controller.
package abuf_ctrl_pkg;

  localparam int ABUF_DEPTH_DEF = 16;
  localparam int ABUF_ADDR_DEF  = $clog2(ABUF_DEPTH_DEF);
  localparam int REP_W_DEF      = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_READ    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } abuf_state_e;

endpackage

// File: rtl/abuf_occ_cnt.sv
// ABUF write pointer and occupancy counter. Writes arriving while full are
// dropped and flagged; a tile release subtracts its length in the same cycle.
module abuf_occ_cnt
  import abuf_ctrl_pkg::*;
#(
  parameter int DEPTH = ABUF_DEPTH_DEF,
  parameter int AW    = ABUF_ADDR_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen_i,
  input  logic          rel_i,
  input  logic [AW:0]   rel_len_i,
  output logic [AW-1:0] wptr_o,
  output logic [AW:0]   occ_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o
);

  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          wen_ok;

  assign full_o  = (occ_q == DEPTH_C);
  assign empty_o = (occ_q == '0);
  assign ovf_o   = wen_i && full_o;
  assign wptr_o  = wptr_q;
  assign occ_o   = occ_q;

  always_comb begin
    wen_ok = wen_i && !full_o;
    wptr_d = wptr_q;
    if (wen_ok) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    // Net update: a legal write and a release may land in the same cycle.
    occ_d = occ_q + {{AW{1'b0}}, wen_ok} - (rel_i ? rel_len_i : '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, and reset is
  // sampled synchronously on the clock edge rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/abuf_ctrl.sv
// Activation buffer controller: write addressing via abuf_occ_cnt, plus the
// tile read sequencer that replays cfg_len rows cfg_repeat times, then releases them.
module abuf_ctrl
  import abuf_ctrl_pkg::*;
#(
  parameter int ABUF_DEPTH = ABUF_DEPTH_DEF,
  parameter int ABUF_ADDR  = $clog2(ABUF_DEPTH),
  parameter int REP_W      = REP_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abuf_wen,
  output logic [ABUF_ADDR-1:0] abuf_waddr,
  input  logic                 cfg_start,
  input  logic [ABUF_ADDR:0]   cfg_len,
  input  logic [REP_W-1:0]     cfg_repeat,
  input  logic                 mac_ready,
  output logic [ABUF_ADDR-1:0] abuf_raddr,
  output logic                 abuf_ren,
  output logic                 busy,
  output logic                 done,
  output logic                 full,
  output logic                 empty,
  output logic                 err
);

  localparam logic [ABUF_ADDR:0]   DEPTH_C  = (ABUF_ADDR + 1)'(ABUF_DEPTH);
  localparam logic [ABUF_ADDR:0]   LEN_ONE  = 1;
  localparam logic [ABUF_ADDR-1:0] ADDR_ONE = 1;
  localparam logic [REP_W-1:0]     REP_ONE  = 1;

  abuf_state_e          state_q, state_d;
  logic [ABUF_ADDR:0]   len_q, len_d;
  logic [REP_W-1:0]     rep_q, rep_d;
  logic [ABUF_ADDR-1:0] rbase_q, rbase_d;
  logic [ABUF_ADDR-1:0] idx_q, idx_d;
  logic [REP_W-1:0]     pass_q, pass_d;
  logic                 err_q, err_d;

  logic [ABUF_ADDR:0]   occ;
  logic                 ovf;
  logic                 release_en;
  logic                 last_row;
  logic                 last_pass;

  abuf_occ_cnt #(
    .DEPTH (ABUF_DEPTH),
    .AW    (ABUF_ADDR)
  ) u_occ (
    .clk       (clk),
    .rst       (rst),
    .wen_i     (abuf_wen),
    .rel_i     (release_en),
    .rel_len_i (len_q),
    .wptr_o    (abuf_waddr),
    .occ_o     (occ),
    .full_o    (full),
    .empty_o   (empty),
    .ovf_o     (ovf)
  );

  assign last_row   = ({1'b0, idx_q} == (len_q - LEN_ONE));
  assign last_pass  = (pass_q == (rep_q - REP_ONE));
  assign abuf_raddr = rbase_q + idx_q;
  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rep_d      = rep_q;
    rbase_d    = rbase_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    err_d      = err_q | ovf;
    abuf_ren   = 1'b0;
    done       = 1'b0;
    release_en = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          len_d  = cfg_len;
          // A repeat count of zero still means one pass over the tile.
          rep_d  = (cfg_repeat == '0) ? REP_ONE : cfg_repeat;
          idx_d  = '0;
          pass_d = '0;
          if (cfg_len == '0) begin
            state_d = ST_DONE;
          end else if (cfg_len > DEPTH_C) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (occ >= len_q) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        abuf_ren = mac_ready;
        if (mac_ready) begin
          if (last_row) begin
            idx_d = '0;
            if (last_pass) begin
              state_d = ST_RELEASE;
            end else begin
              pass_d = pass_q + REP_ONE;
            end
          end else begin
            idx_d = idx_q + ADDR_ONE;
          end
        end
      end
      ST_RELEASE: begin
        // len == DEPTH truncates to zero, which is the correct modulo step.
        rbase_d    = rbase_q + len_q[ABUF_ADDR-1:0];
        release_en = 1'b1;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      rep_q   <= '0;
      rbase_q <= '0;
      idx_q   <= '0;
      pass_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      rbase_q <= rbase_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

endmodule
